// File: rtl/host_mem_bridge.sv
// Host-side bridge: streams host characters into data RAM, arbitrates the RAM
// port between host load, CPU execution and read-back, and supervises CPU runs.
module host_mem_bridge #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int CHAR_W   = 8,
    parameter int BUF_BASE = 1500,
    parameter int BUF_LEN  = 108,
    parameter int NUM_PROG = 2,
    parameter int HALT_REG = 28
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [1:0]                     mode,
    input  logic                           char_valid,
    input  logic [CHAR_W-1:0]              char_data,
    output logic                           char_ready,
    output logic [$clog2(BUF_LEN+1)-1:0]   load_count,
    output logic                           load_done,
    input  logic [1:0]                     prog_sel,
    output logic [1:0]                     prog_latched,
    output logic                           cpu_reset,
    input  logic [DATA_W-1:0]              cpu_addr,
    input  logic [DATA_W-1:0]              cpu_data,
    input  logic                           cpu_wren,
    input  logic                           cpu_rwe,
    input  logic [4:0]                     cpu_rd,
    input  logic [DATA_W-1:0]              cpu_rdata,
    input  logic [ADDR_W-1:0]              read_addr,
    output logic [ADDR_W-1:0]              ram_addr,
    output logic [DATA_W-1:0]              ram_din,
    output logic                           ram_wen,
    output logic                           halted,
    output logic [31:0]                    exec_cycles
);

    localparam int CW = $clog2(BUF_LEN + 1);
    localparam logic [CW-1:0]     LEN_C  = CW'(BUF_LEN);
    localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BUF_BASE);
    localparam logic [4:0]        HALT_C = 5'(HALT_REG);
    localparam logic [DATA_W-1:0] ONE_C  = DATA_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EXEC = 2'b10,
        READ = 2'b11
    } state_t;

    state_t state;
    logic   prog_valid;
    logic   prog_ok;
    logic   transfer;
    logic   run;
    logic   halt_write;
    logic   unused_addr_bits;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
        return (v >= LEN_C) ? LEN_C : v + CW'(1);
    endfunction

    assign prog_ok    = (32'(prog_sel) < 32'(NUM_PROG));
    assign char_ready = (state == LOAD) && (load_count < LEN_C);
    assign transfer   = char_ready & char_valid;
    // The CPU only runs with a valid image and until it writes the halt value.
    assign run        = (state == EXEC) & prog_valid & ~halted;
    assign cpu_reset  = ~run;
    assign halt_write = run & cpu_rwe & (cpu_rd == HALT_C) & (cpu_rdata == ONE_C);

    assign unused_addr_bits = ^cpu_addr[DATA_W-1:ADDR_W];

    always_comb begin
        ram_addr = read_addr;
        ram_din  = '0;
        ram_wen  = 1'b0;
        case (state)
            LOAD: begin
                ram_addr = BASE_C + ADDR_W'(load_count);
                if (transfer) begin
                    ram_din = DATA_W'(char_data);
                    ram_wen = 1'b1;
                end
            end
            EXEC: begin
                ram_addr = cpu_addr[ADDR_W-1:0];
                ram_din  = cpu_data;
                ram_wen  = cpu_wren & run;
            end
            default: begin
                ram_addr = read_addr;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            load_count   <= '0;
            load_done    <= 1'b0;
            prog_latched <= 2'b00;
            prog_valid   <= 1'b0;
            halted       <= 1'b0;
            exec_cycles  <= '0;
        end else begin
            state <= state_t'(mode);

            if (transfer) begin
                load_count <= sat_inc_cnt(load_count);
                load_done  <= (sat_inc_cnt(load_count) == LEN_C);
            end

            if (run) begin
                exec_cycles <= sat_inc32(exec_cycles);
                if (halt_write) halted <= 1'b1;
            end

            // Entry actions; they never coincide with the in-state updates above.
            if ((mode == LOAD) && (state != LOAD)) begin
                load_count <= '0;
                load_done  <= 1'b0;
            end

            if ((mode == EXEC) && (state != EXEC)) begin
                prog_latched <= prog_ok ? prog_sel : 2'b00;
                prog_valid   <= prog_ok;
                halted       <= 1'b0;
                exec_cycles  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_host_mem_bridge.sv
// Scoreboard bench for host_mem_bridge: stimulus pushes expected per-cycle outputs
// and RAM writes from a spec-level model; a negedge monitor pops and compares.
module tb_host_mem_bridge;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int CHAR_W   = 8;
    localparam int BUF_BASE = 1500;
    localparam int BUF_LEN  = 108;
    localparam int NUM_PROG = 2;
    localparam int HALT_REG = 28;
    localparam int CW       = $clog2(BUF_LEN + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic              char_valid;
    logic [CHAR_W-1:0] char_data;
    logic              char_ready;
    logic [CW-1:0]     load_count;
    logic              load_done;
    logic [1:0]        prog_sel;
    logic [1:0]        prog_latched;
    logic              cpu_reset;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_wren;
    logic              cpu_rwe;
    logic [4:0]        cpu_rd;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_wen;
    logic              halted;
    logic [31:0]       exec_cycles;

    host_mem_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHAR_W(CHAR_W), .BUF_BASE(BUF_BASE),
        .BUF_LEN(BUF_LEN), .NUM_PROG(NUM_PROG), .HALT_REG(HALT_REG)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .load_count(load_count), .load_done(load_done),
        .prog_sel(prog_sel), .prog_latched(prog_latched), .cpu_reset(cpu_reset),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
        .cpu_rwe(cpu_rwe), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
        .read_addr(read_addr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen),
        .halted(halted), .exec_cycles(exec_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] din;
        logic        ready;
        logic        creset;
        int          cnt;
        logic        done;
        logic [1:0]  plat;
        logic        halted;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sq[$];
    logic [43:0] wq[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference state, in the terms of the behavioural description.
    int          m_st     = 0;
    int          m_cnt    = 0;
    bit          m_done   = 0;
    bit          m_pvalid = 0;
    bit          m_halted = 0;
    logic [1:0]  m_plat   = 2'b00;
    logic [31:0] m_cyc    = 32'd0;
    bit          xfer_last = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        exp_t e;
        bit   creset;
        e.ready  = (m_st == 1) && (m_cnt < BUF_LEN);
        creset   = !((m_st == 2) && m_pvalid && !m_halted);
        e.creset = creset;
        e.wen    = 1'b0;
        e.addr   = read_addr;
        e.din    = 32'd0;
        if (m_st == 1) begin
            e.addr = 12'(BUF_BASE + m_cnt);
            if (e.ready && char_valid) begin
                e.wen = 1'b1;
                e.din = 32'(char_data);
            end
        end else if (m_st == 2) begin
            e.addr = cpu_addr[11:0];
            e.din  = cpu_data;
            e.wen  = cpu_wren && !creset;
        end
        e.cnt    = m_cnt;
        e.done   = m_done;
        e.plat   = m_plat;
        e.halted = m_halted;
        e.cyc    = m_cyc;
        sq.push_back(e);
        if (e.wen) wq.push_back({e.addr, e.din});
        xfer_last = (m_st == 1) && e.ready && char_valid;

        @(posedge clock);
        if (reset) begin
            m_st = 0; m_cnt = 0; m_done = 0; m_pvalid = 0;
            m_halted = 0; m_plat = 2'b00; m_cyc = 32'd0;
        end else begin
            if (xfer_last) begin
                m_cnt++;
                if (m_cnt == BUF_LEN) m_done = 1;
            end
            if (m_st == 2 && !creset) begin
                if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
                if (cpu_rwe && cpu_rd == 5'(HALT_REG) && cpu_rdata == 32'd1) m_halted = 1;
            end
            if (mode == 2'b01 && m_st != 1) begin
                m_cnt = 0; m_done = 0;
            end
            if (mode == 2'b10 && m_st != 2) begin
                m_pvalid = (int'(prog_sel) < NUM_PROG);
                m_plat   = m_pvalid ? prog_sel : 2'b00;
                m_halted = 0;
                m_cyc    = 32'd0;
            end
            m_st = int'(mode);
        end
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [43:0] w;
        forever begin
            @(negedge clock);
            if (ram_wen === 1'b1) begin
                if (wq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL ram_write: got unexpected write addr %0d data %0h", ram_addr, ram_din);
                end else begin
                    w = wq.pop_front();
                    chk("ram_write", {20'd0, ram_addr, ram_din}, {20'd0, w});
                end
            end
            if (sq.size() != 0) begin
                e = sq.pop_front();
                chk("ram_wen", ram_wen, e.wen);
                chk("ram_addr", ram_addr, e.addr);
                chk("ram_din", ram_din, e.din);
                chk("char_ready", char_ready, e.ready);
                chk("cpu_reset", cpu_reset, e.creset);
                chk("load_count", 64'(load_count), 64'(e.cnt));
                chk("load_done", load_done, e.done);
                chk("prog_latched", prog_latched, e.plat);
                chk("halted", halted, e.halted);
                chk("exec_cycles", exec_cycles, e.cyc);
            end
        end
    end

    initial begin : stimulus
        int hold;
        reset = 1'b1; mode = 2'b00; char_valid = 1'b0; char_data = '0;
        prog_sel = 2'b00; cpu_addr = '0; cpu_data = '0; cpu_wren = 1'b0;
        cpu_rwe = 1'b0; cpu_rd = '0; cpu_rdata = '0; read_addr = '0;
        @(posedge clock);
        #1;
        cycle();
        chk("reset_cpu_reset", cpu_reset, 1'b1);
        chk("reset_load_count", 64'(load_count), 64'd0);
        chk("reset_char_ready", char_ready, 1'b0);
        reset = 1'b0;

        // Full buffer load with valid held high.
        mode = 2'b01; char_valid = 1'b1;
        for (int i = 0; i < 112; i++) begin
            char_data = 8'(65 + m_cnt);
            cycle();
        end
        chk("full_load_count", 64'(load_count), 64'd108);
        chk("full_load_done", load_done, 1'b1);
        chk("full_char_ready", char_ready, 1'b0);

        // Reset while in LOAD clears the load progress.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_mid_count", 64'(load_count), 64'd0);
        chk("rst_mid_done", load_done, 1'b0);

        // Interrupted load, re-entry restarts at the buffer base.
        for (int i = 0; i < 6; i++) begin
            char_data = 8'(65 + m_cnt);
            cycle();
        end
        chk("partial_count", 64'(load_count), 64'd5);
        char_valid = 1'b0; mode = 2'b00;
        cycle();
        cycle();
        chk("frozen_count", 64'(load_count), 64'd5);
        mode = 2'b01;
        cycle();
        chk("reentry_count", 64'(load_count), 64'd0);
        char_valid = 1'b1; char_data = 8'h5A;
        #1;
        chk("reentry_addr", ram_addr, 12'd1500);
        chk("reentry_wen", ram_wen, 1'b1);
        cycle();
        char_valid = 1'b0;

        // Run program 1 and halt at run cycle 40.
        mode = 2'b10; prog_sel = 2'b01;
        cycle();
        for (int i = 0; i < 40; i++) begin
            if (i == 3) prog_sel = 2'b10;
            cpu_addr = $urandom; cpu_data = $urandom; cpu_wren = 1'($urandom);
            cpu_rwe = 1'($urandom); cpu_rd = 5'($urandom_range(0, 27)); cpu_rdata = 32'd1;
            cycle();
        end
        chk("run_prog_latched", prog_latched, 2'b01);
        chk("run_cpu_reset", cpu_reset, 1'b0);
        cpu_rwe = 1'b1; cpu_rd = 5'(HALT_REG); cpu_rdata = 32'd1;
        cycle();
        cpu_rwe = 1'b0;
        chk("halt_flag", halted, 1'b1);
        chk("halt_cpu_reset", cpu_reset, 1'b1);
        chk("halt_exec_cycles", exec_cycles, 32'd41);
        cycle();
        mode = 2'b11;
        cycle();
        cycle();
        chk("hold_exec_cycles", exec_cycles, 32'd41);
        chk("hold_halted", halted, 1'b1);
        chk("hold_prog_latched", prog_latched, 2'b01);

        // Invalid program keeps the CPU in reset.
        mode = 2'b10; prog_sel = 2'b11; cpu_wren = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("badprog_cpu_reset", cpu_reset, 1'b1);
        chk("badprog_exec_cycles", exec_cycles, 32'd0);
        chk("badprog_latched", prog_latched, 2'b00);
        chk("badprog_wen", ram_wen, 1'b0);

        // Read-back ignores CPU writes.
        mode = 2'b11; read_addr = 12'd1503;
        cycle();
        cycle();
        chk("read_wen", ram_wen, 1'b0);
        chk("read_addr", ram_addr, 12'd1503);

        // Halt write on the edge that leaves EXEC is still captured.
        mode = 2'b10; prog_sel = 2'b00; cpu_wren = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        mode = 2'b00; cpu_rwe = 1'b1; cpu_rd = 5'(HALT_REG); cpu_rdata = 32'd1;
        cycle();
        cpu_rwe = 1'b0;
        chk("exit_halt", halted, 1'b1);
        chk("exit_exec_cycles", exec_cycles, 32'd5);

        // Randomised traffic.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                mode = 2'($urandom);
                hold = $urandom_range(1, 40);
            end
            hold--;
            reset = ($urandom_range(0, 199) == 0);
            if (!(char_valid && !xfer_last)) char_data = 8'($urandom);
            char_valid = ($urandom_range(0, 3) != 0);
            prog_sel   = 2'($urandom);
            cpu_addr   = $urandom;
            cpu_data   = $urandom;
            cpu_wren   = 1'($urandom);
            read_addr  = 12'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                cpu_rwe = 1'b1; cpu_rd = 5'(HALT_REG); cpu_rdata = 32'd1;
            end else begin
                cpu_rwe = 1'($urandom); cpu_rd = 5'($urandom);
                cpu_rdata = 32'($urandom_range(0, 3));
            end
            cycle();
        end

        reset = 1'b0; mode = 2'b00; char_valid = 1'b0; cpu_rwe = 1'b0;
        cycle();
        cycle();
        @(negedge clock);
        #1;
        chk("status_queue_drained", 64'(sq.size()), 64'd0);
        chk("write_queue_drained", 64'(wq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/host_mem_bridge.md
# host_mem_bridge

Parametrised host-side bridge between the board controls, the processor, and the data RAM. It streams a host character buffer into RAM using a valid/ready handshake with a completion flag. It arbitrates the RAM port between host load, CPU execution and host read-back. It also gates CPU reset, latches the program selection, detects a halt write to a designated register, and counts execution cycles.

## Interface

Parameters:
- ADDR_W, 12, RAM address width
- DATA_W, 32, RAM data width
- CHAR_W, 8, host character width
- BUF_BASE, 1500, RAM address of the first buffer character
- BUF_LEN, 108, buffer length in characters (1..2^ADDR_W-BUF_BASE)
- NUM_PROG, 2, number of valid program images
- HALT_REG, 28, register index whose write of value 1 signals halt

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mode  in  2  00 idle, 01 load, 10 exec, 11 read-back
- char_valid  in  1  host character present
- char_data  in  CHAR_W  host character
- char_ready  out  1  bridge accepts character this cycle
- load_count  out  CW=$clog2(BUF_LEN+1)  characters written since load entry
- load_done  out  1  buffer full
- prog_sel  in  2  program request
- prog_latched  out  2  program select driven to instruction ROM mux
- cpu_reset  out  1  processor reset
- cpu_addr  in  DATA_W  processor dmem address (low ADDR_W bits used)
- cpu_data  in  DATA_W  processor dmem write data
- cpu_wren  in  1  processor dmem write enable
- cpu_rwe  in  1  processor regfile write enable
- cpu_rd  in  5  processor regfile write index
- cpu_rdata  in  DATA_W  processor regfile write data
- read_addr  in  ADDR_W  host read-back address
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_wen  out  1  RAM write enable
- halted  out  1  sticky halt flag
- exec_cycles  out  32  cycles executed in current run

## Operation

- States: IDLE, LOAD, EXEC, READ. The state register loads the decode of `mode` every cycle; a mode change takes effect on the next edge.
- Entering LOAD from any other state clears load_count and load_done.
- LOAD: char_ready = (load_count < BUF_LEN). When char_valid & char_ready, drive ram_wen=1, ram_addr=BUF_BASE+load_count, and ram_din = zero-extended char_data. load_count then increments on the edge.
- load_done is registered. It rises on the edge where load_count reaches BUF_LEN. load_count saturates at BUF_LEN; once full, no further writes occur and char_ready=0.
- Leaving LOAD mid-buffer leaves load_count/load_done frozen until the next LOAD entry.
- Entering EXEC does the following:
  - prog_latched <= prog_sel, held for the whole EXEC stay.
  - exec_cycles and halted are cleared.
  - If prog_sel >= NUM_PROG, prog_latched = 0 and cpu_reset stays 1 for the whole EXEC stay.
- EXEC: cpu_reset = 0 unless halted or the program is invalid. ram_addr=cpu_addr[ADDR_W-1:0], ram_din=cpu_data, ram_wen=cpu_wren & ~cpu_reset.
- Halt: in EXEC with cpu_reset=0, if cpu_rwe & cpu_rd==HALT_REG & cpu_rdata==1, halted sets on that edge. From the next cycle, cpu_reset=1 and exec_cycles freezes.
- exec_cycles increments on each edge in EXEC with cpu_reset=0 and saturates at 0xFFFFFFFF.
- READ: ram_addr=read_addr, ram_wen=0. Data comes back from the RAM with its own one-cycle latency, outside this block.
- IDLE: ram_addr=read_addr, ram_wen=0, char_ready=0.
- cpu_reset=1 in every state except EXEC.
- halted, exec_cycles and prog_latched hold their values in IDLE and READ, so results stay readable after a run.

## Timing

- Reset values:
  - state=IDLE, load_count=0, load_done=0, prog_latched=0, halted=0, exec_cycles=0
  - cpu_reset=1, char_ready=0, ram_wen=0, ram_addr=read_addr, ram_din=0
- Mode-to-state latency is 1 cycle. cpu_reset falls 1 cycle after mode first reads 10 at an edge.
- Handshake: a transfer happens on an edge where char_valid & char_ready are both high. char_data must be stable while char_valid=1. char_ready is combinational from state and load_count only, never from char_valid.
- Reset wins over every other event, including mid-load and mid-exec.
- A halt write on the same edge that mode leaves EXEC: halted is still captured.
- Counter increment at saturation holds its value; there is no wrap.

## Test plan

- Reset, mode=01, stream 108 chars 0x41.. with char_valid held high -> ram_wen pulses at addresses 1500..1607, load_count=108, load_done=1 the cycle after the last write, char_ready=0 after that.
- mode=01, send 5 chars, then mode=00, then mode=01 again -> load_count returns to 0, and the next char is written to address 1500.
- mode=10 with prog_sel=01 -> prog_latched=01, cpu_reset=0 one cycle later. Changing prog_sel to 10 during EXEC leaves prog_latched=01.
- In EXEC, drive cpu_rwe=1, cpu_rd=28, cpu_rdata=1 at cycle 40 of the run -> halted=1, cpu_reset=1 the next cycle, exec_cycles frozen at 41. Values are held after mode=11.
- mode=10 with prog_sel=11 -> cpu_reset stays 1, exec_cycles stays 0, prog_latched=0.
- mode=11, read_addr=1503, cpu_wren=1 driven -> ram_wen=0 and ram_addr=1503. Asserting reset mid-load clears load_count and load_done.
